// File: rtl/motor_dir_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_pkg : direction codes, H-bridge patterns, sequencer states     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package motor_pkg;

  localparam logic [3:0] DIR_FWD   = 4'b1001;
  localparam logic [3:0] DIR_REV   = 4'b0110;
  localparam logic [3:0] DIR_LEFT  = 4'b1010;
  localparam logic [3:0] DIR_RIGHT = 4'b0101;
  localparam logic [3:0] DIR_OFF   = 4'b0000;

  localparam logic [1:0] CODE_FWD   = 2'b00;
  localparam logic [1:0] CODE_REV   = 2'b11;
  localparam logic [1:0] CODE_LEFT  = 2'b10;
  localparam logic [1:0] CODE_RIGHT = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_DEAD      = 2'd2
  } state_t;

  function automatic logic [3:0] dir_encode(input logic [1:0] code);
    logic [3:0] pat;
    case (code)
      CODE_FWD:   pat = DIR_FWD;
      CODE_REV:   pat = DIR_REV;
      CODE_LEFT:  pat = DIR_LEFT;
      CODE_RIGHT: pat = DIR_RIGHT;
      default:    pat = DIR_OFF;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_dir_sequencer_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen : free-running prescaler, one-cycle tick every DIV clocks   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/motor_dir_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | motor_dir_sequencer : slew-limited duty, ramp-down + dead time on   |
// | direction change before energising the H-bridge again. Rev 1.0      |
// +--------------------------------------------------------------------+
module motor_dir_sequencer
  import motor_pkg::*;
#(
  parameter int DUTY_W      = 6,
  parameter int RAMP_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_speed,
  input  logic [1:0]        sw_dir,
  output logic [DUTY_W-1:0] duty_out,
  output logic [3:0]        tank_dir,
  output logic              busy
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] C_DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  logic [DUTY_W-1:0] r_spd_m, r_spd_s;
  logic [1:0]        r_dir_m, r_dir_s;
  logic [1:0]        r_cur_dir;
  logic [DW-1:0]     r_dead_cnt;
  state_t            r_state;
  logic              w_tick;

  tick_gen #(.DIV(RAMP_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Switches are asynchronous to clk; two flops each before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spd_m <= '0;
      r_spd_s <= '0;
      r_dir_m <= '0;
      r_dir_s <= '0;
    end else begin
      r_spd_m <= sw_speed;
      r_spd_s <= r_spd_m;
      r_dir_m <= sw_dir;
      r_dir_s <= r_dir_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_DEAD;
      r_cur_dir  <= CODE_FWD;
      r_dead_cnt <= C_DEAD_LOAD;
      duty_out   <= '0;
      tank_dir   <= DIR_OFF;
      busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_dir_s != r_cur_dir) begin
            r_state <= ST_RAMP_DOWN;
            busy    <= 1'b1;
          end else if (w_tick) begin
            if (duty_out < r_spd_s) begin
              duty_out <= duty_out + DUTY_W'(1);
            end else if (duty_out > r_spd_s) begin
              duty_out <= duty_out - DUTY_W'(1);
            end
          end
        end
        ST_RAMP_DOWN: begin
          // Returning to the running direction aborts without any dead time.
          if (r_dir_s == r_cur_dir) begin
            r_state <= ST_RUN;
            busy    <= 1'b0;
          end else if (duty_out == '0) begin
            r_state    <= ST_DEAD;
            tank_dir   <= DIR_OFF;
            r_dead_cnt <= C_DEAD_LOAD;
          end else if (w_tick) begin
            duty_out <= duty_out - DUTY_W'(1);
          end
        end
        ST_DEAD: begin
          duty_out <= '0;
          if (r_dead_cnt == '0) begin
            r_cur_dir <= r_dir_s;
            tank_dir  <= dir_encode(r_dir_s);
            r_state   <= ST_RUN;
            busy      <= 1'b0;
          end else begin
            r_dead_cnt <= r_dead_cnt - DW'(1);
          end
        end
        default: begin
          r_state    <= ST_DEAD;
          r_dead_cnt <= C_DEAD_LOAD;
          duty_out   <= '0;
          tank_dir   <= DIR_OFF;
          busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_dir_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_motor_dir_sequencer : directed bench, RAMP_DIV=4 DEAD_CYCLES=10   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_motor_dir_sequencer;

  localparam int DUTY_W      = 6;
  localparam int RAMP_DIV    = 4;
  localparam int DEAD_CYCLES = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DUTY_W-1:0] sw_speed;
  logic [1:0]        sw_dir;
  logic [DUTY_W-1:0] duty_out;
  logic [3:0]        tank_dir;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] dir;
    logic [3:0] pat;
  } vec_t;
  vec_t vecs[4];

  motor_dir_sequencer #(
    .DUTY_W      (DUTY_W),
    .RAMP_DIV    (RAMP_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_speed (sw_speed),
    .sw_dir   (sw_dir),
    .duty_out (duty_out),
    .tank_dir (tank_dir),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_duty(input int v, input int lim, input string nm, output int cyc);
    cyc = 0;
    while (int'(duty_out) != v && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    if (int'(duty_out) != v) check({nm, " timeout"}, int'(duty_out), v);
  endtask

  task automatic wait_tank(input int v, input int lim, input string nm, output int cyc);
    cyc = 0;
    while (int'(tank_dir) != v && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    if (int'(tank_dir) != v) check({nm, " timeout"}, int'(tank_dir), v);
  endtask

  // Waits for the bridge to go off, then counts samples it stays off.
  task automatic dead_len(input string nm, input int toggle_at, input logic [1:0] new_dir,
                          output int enter_cyc);
    int z;
    wait_tank(0, 80, {nm, " enter"}, enter_cyc);
    check({nm, " duty at dead"}, int'(duty_out), 0);
    z = 0;
    while (tank_dir == 4'b0000 && z < 50) begin
      z++;
      if (toggle_at > 0 && z == toggle_at) sw_dir = new_dir;
      @(negedge clk);
    end
    check({nm, " dead len"}, z, DEAD_CYCLES);
  endtask

  task automatic release_reset(input string nm);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (tank_dir == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, " off after reset"}, n, DEAD_CYCLES);
  endtask

  // Continuous safety properties: no direct pattern-to-pattern switch, unit duty steps.
  logic [3:0]        mon_tank;
  logic [DUTY_W-1:0] mon_duty;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_tank = 4'b0000;
      mon_duty = '0;
    end else begin
      if (tank_dir != mon_tank)
        check("tank direct switch", int'(mon_tank != 4'b0000 && tank_dir != 4'b0000), 0);
      if (duty_out != mon_duty)
        check("duty step size",
              (duty_out > mon_duty) ? int'(duty_out - mon_duty) : int'(mon_duty - duty_out), 1);
      mon_tank = tank_dir;
      mon_duty = duty_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  c;
    bit  moved;
    bit  saw_busy;

    vecs[0] = '{dir: 2'b11, pat: 4'b0110};
    vecs[1] = '{dir: 2'b10, pat: 4'b1010};
    vecs[2] = '{dir: 2'b01, pat: 4'b0101};
    vecs[3] = '{dir: 2'b00, pat: 4'b1001};

    rst_n    = 1'b0;
    sw_speed = 6'd20;
    sw_dir   = 2'b00;
    repeat (3) @(negedge clk);
    check("reset duty", int'(duty_out), 0);
    check("reset tank", int'(tank_dir), 0);
    check("reset busy", int'(busy), 1);

    // Power-up: full dead period, then forward and ramp to 20.
    release_reset("powerup");
    check("powerup tank", int'(tank_dir), 4'b1001);
    check("powerup busy", int'(busy), 0);
    wait_duty(20, 200, "ramp to 20", c);
    check("ramp to 20 cycles", c, 78);
    repeat (12) @(negedge clk);
    check("hold 20", int'(duty_out), 20);

    // Speed-only change tracks down without any dead time.
    sw_speed = 6'd5;
    wait_duty(5, 200, "ramp to 5", c);
    check("ramp to 5 cycles", c, 60);
    check("speed chg tank", int'(tank_dir), 4'b1001);
    check("speed chg busy", int'(busy), 0);
    repeat (12) @(negedge clk);
    check("hold 5", int'(duty_out), 5);

    // Reverse at duty 8.
    sw_speed = 6'd8;
    wait_duty(8, 100, "ramp to 8", c);
    sw_dir = 2'b11;
    dead_len("fwd->rev", 0, 2'b11, c);
    check("fwd->rev ramp cycles", c, 33);
    check("rev tank", int'(tank_dir), 4'b0110);
    check("rev busy", int'(busy), 0);
    wait_duty(8, 100, "rev ramp up", c);

    // Brief direction glitch aborts the ramp-down.
    sw_dir = 2'b10;
    repeat (6) @(negedge clk);
    sw_dir   = 2'b11;
    moved    = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tank_dir != 4'b0110) moved = 1'b1;
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("abort tank held", int'(moved), 0);
    check("abort saw busy", int'(saw_busy), 1);
    check("abort busy cleared", int'(busy), 0);
    wait_duty(8, 60, "abort resume", c);
    check("abort resume duty", int'(duty_out), 8);

    // Direction toggles inside DEAD do not stretch it; last value wins.
    sw_dir = 2'b10;
    dead_len("dead toggle", 3, 2'b01, c);
    check("dead toggle tank", int'(tank_dir), 4'b0101);

    // Reset in the middle of a reverse ramp-down.
    sw_speed = 6'd5;
    sw_dir   = 2'b11;
    dead_len("to rev", 0, 2'b11, c);
    wait_duty(5, 100, "rev to 5", c);
    sw_dir = 2'b00;
    c = 0;
    while (!busy && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("ramp down busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    check("mid ramp duty nonzero", int'(duty_out != '0), 1);
    rst_n = 1'b0;
    #1;
    check("async reset duty", int'(duty_out), 0);
    check("async reset tank", int'(tank_dir), 0);
    check("async reset busy", int'(busy), 1);
    sw_speed = 6'd0;
    release_reset("mid reset");
    check("mid reset tank", int'(tank_dir), 4'b1001);

    // Zero-duty direction changes: one cycle in RAMP_DOWN, then DEAD.
    foreach (vecs[k]) begin
      sw_dir = vecs[k].dir;
      dead_len($sformatf("vec%0d", k), 0, vecs[k].dir, c);
      check($sformatf("vec%0d enter", k), c, 4);
      check($sformatf("vec%0d tank", k), int'(tank_dir), int'(vecs[k].pat));
      check($sformatf("vec%0d busy", k), int'(busy), 0);
    end

    // Full-scale setpoint saturates at the top code.
    sw_speed = 6'd63;
    wait_duty(63, 400, "ramp to 63", c);
    repeat (20) @(negedge clk);
    check("saturate 63", int'(duty_out), 63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
